i2c_apb_sequencer: RTL and testbench
====================================

Name: i2c_apb_sequencer

Overview:
APB master that runs complete single-byte I2C transactions on the i2c_top register map for two requesters. It arbitrates round-robin between the requesters. For the granted job it programs prescale, slave address, transmit data and command, then polls status until the byte completes. It then disables the engine and returns the read byte. It sits between host-side logic and the i2c_top APB slave port, in the APB clock domain.

Parameters:
DATA_SIZE, 8, APB data width
ADDR_SIZE, 8, APB address width
ADDR_PRESCALE, 8'h00, prescale register address
ADDR_COMMAND, 8'h01, command register address
ADDR_STATUS, 8'h02, status register address
ADDR_TRANSMIT, 8'h03, transmit (TX-FIFO) register address
ADDR_RECEIVE, 8'h04, receive (RX-FIFO) register address
ADDR_SLAVE, 8'h05, slave address register address
TX_EMPTY_BIT, 7, status bit index for TX-FIFO empty
RX_EMPTY_BIT, 3, status bit index for RX-FIFO empty
TIMEOUT_CYCLES, 1024, poll limit (optional feature only)

Ports:
pclk_i  in  1  clock
preset_ni  in  1  asynchronous active-low reset
prescale_i  in  8  value written to prescale register for every job
req_i  in  2  job request per requester; level, held until grant
req0_addr_i  in  8  requester 0 slave address; bit0 = rw (1 read)
req0_wdata_i  in  8  requester 0 write byte
req1_addr_i  in  8  requester 1 slave address; bit0 = rw (1 read)
req1_wdata_i  in  8  requester 1 write byte
gnt_o  out  2  one-hot grant, held for the whole job
done_o  out  1  one-cycle pulse at job end
rdata_o  out  8  read byte; valid with done_o for read jobs, held after
busy_o  out  1  high from grant to done
paddr_o  out  ADDR_SIZE  APB address
pwrite_o  out  1  APB direction
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwdata_o  out  DATA_SIZE  APB write data
prdata_i  in  DATA_SIZE  APB read data
pready_i  in  1  APB ready

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours requester 0.
- APB transfer:
  - SETUP cycle: psel=1, penable=0; paddr, pwrite and pwdata are valid.
  - ACCESS cycle(s): psel=1, penable=1, held until pready_i=1.
  - prdata_i is sampled on the pready cycle; the next cycle starts the next SETUP or returns to IDLE.
  - Each transfer takes at least 2 cycles; there are no idle cycles between transfers within a job.
- Arbitration (IDLE):
  - With req_i != 0, grant in the next cycle.
  - Priority goes to the requester not served last; a single requester is granted directly.
  - The job's addr/wdata are latched at grant; later input changes are ignored.
- Sequence after grant, one APB transfer per state:
  - WR_PRESCALE: write prescale_i.
  - WR_SLAVE: write the latched addr.
  - WR_TXDATA: write wdata; write jobs only, skipped for reads.
  - WR_CMD_GO: write 8'hC0 (reset_n=1, enable=1).
  - POLL: read ADDR_STATUS.
    - Write job completes when status[TX_EMPTY_BIT]=1.
    - Read job completes when status[RX_EMPTY_BIT]=0.
    - Otherwise POLL repeats back-to-back.
  - RD_DATA: read ADDR_RECEIVE into rdata_o; read jobs only.
  - WR_CMD_STOP: write 8'h80 (enable=0, reset_n=1).
  - DONE: done_o=1 for one cycle; gnt_o and busy_o clear in the same cycle; go to IDLE.
- Polling has no upper bound unless the optional feature is compiled in.
- Requests arriving during a job wait; they do not preempt it.
- A request dropped before grant is not granted.
- Asynchronous reset mid-transfer:
  - psel and penable drop immediately; the APB transfer is abandoned.
  - The grant clears and the round-robin pointer resets.

Optional Feature:
Macro I2C_SEQ_TIMEOUT_EN.
- With it:
  - Adds output timeout_o (1 bit, reset 0) and a poll cycle counter, cleared on entry to POLL.
  - If the counter reaches TIMEOUT_CYCLES before completion, the block goes to WR_CMD_STOP, then DONE.
  - In that DONE cycle timeout_o=1 together with done_o, and rdata_o stays unchanged.
- Without it: no timeout_o port, no counter, unbounded polling.

Test Plan:
- Write job, req0 addr 8'hA0, wdata 8'h5A, prescale 8'h04, pready always 1 → APB writes (00←04), (05←A0), (03←5A), (01←C0); status polls return 8'h00 twice then 8'h80; then (01←80); done_o pulses, rdata_o unchanged.
- Read job, req1 addr 8'hA1 → no write to 03; polls see 8'h08 then 8'h00; read of 04 returns 8'h3C; rdata_o=8'h3C with done_o.
- Both req_i=2'b11 continuously from reset → grants alternate 01,10,01,10 across four jobs; gnt_o is never two-hot.
- pready_i low for 3 cycles on every ACCESS → each transfer lasts 5 cycles; paddr, pwdata and psel stable throughout.
- preset_ni asserted during WR_TXDATA ACCESS → all outputs 0 immediately; after release a pending req0 restarts from WR_PRESCALE.
- With I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, status stuck at 8'h00 on a write job → stop command 8'h80 written; done_o and timeout_o both 1 in the same cycle.

Source files
------------

// File: rtl/i2c_apb_sequencer.sv
// ============================================================================
// Module   : i2c_apb_sequencer
// Purpose  : Round-robin APB master running single-byte I2C jobs on i2c_top
//            for two requesters. Define I2C_SEQ_TIMEOUT_EN to bound polling.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_apb_sequencer #(
  parameter int                   DATA_SIZE      = 8,
  parameter int                   ADDR_SIZE      = 8,
  parameter logic [ADDR_SIZE-1:0] ADDR_PRESCALE  = 8'h00,
  parameter logic [ADDR_SIZE-1:0] ADDR_COMMAND   = 8'h01,
  parameter logic [ADDR_SIZE-1:0] ADDR_STATUS    = 8'h02,
  parameter logic [ADDR_SIZE-1:0] ADDR_TRANSMIT  = 8'h03,
  parameter logic [ADDR_SIZE-1:0] ADDR_RECEIVE   = 8'h04,
  parameter logic [ADDR_SIZE-1:0] ADDR_SLAVE     = 8'h05,
  parameter int                   TX_EMPTY_BIT   = 7,
  parameter int                   RX_EMPTY_BIT   = 3,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                 pclk_i,
  input  logic                 preset_ni,
  input  logic [7:0]           prescale_i,
  input  logic [1:0]           req_i,
  input  logic [7:0]           req0_addr_i,
  input  logic [7:0]           req0_wdata_i,
  input  logic [7:0]           req1_addr_i,
  input  logic [7:0]           req1_wdata_i,
  output logic [1:0]           gnt_o,
  output logic                 done_o,
  output logic [7:0]           rdata_o,
  output logic                 busy_o,
`ifdef I2C_SEQ_TIMEOUT_EN
  output logic                 timeout_o,
`endif
  output logic [ADDR_SIZE-1:0] paddr_o,
  output logic                 pwrite_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic [DATA_SIZE-1:0] pwdata_o,
  input  logic [DATA_SIZE-1:0] prdata_i,
  input  logic                 pready_i
);

  localparam logic [DATA_SIZE-1:0] c_CMD_GO   = DATA_SIZE'(8'hC0);
  localparam logic [DATA_SIZE-1:0] c_CMD_STOP = DATA_SIZE'(8'h80);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PRESCALE, S_WR_SLAVE, S_WR_TXDATA, S_WR_CMD_GO,
    S_POLL, S_RD_DATA, S_WR_CMD_STOP, S_DONE
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_gnt;
  logic                   r_last;
  logic [7:0]             r_addr;
  logic [7:0]             r_wdata;
  logic                   r_busy;
  logic                   r_done;
  logic [7:0]             r_rdata;
  logic                   r_psel;
  logic                   r_penable;
  logic                   r_pwrite;
  logic [ADDR_SIZE-1:0]   r_paddr;
  logic [DATA_SIZE-1:0]   r_pwdata;

  logic                   w_rw;
  logic                   w_status_ok;
  logic                   w_expired;
  logic [1:0]             w_pick;
  state_t                 w_nxt;
  logic [ADDR_SIZE-1:0]   w_tgt_addr;
  logic                   w_tgt_write;
  logic [DATA_SIZE-1:0]   w_tgt_wdata;

  assign w_rw        = r_addr[0];
  assign w_status_ok = w_rw ? ~prdata_i[RX_EMPTY_BIT] : prdata_i[TX_EMPTY_BIT];

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

  logic [c_CNT_W-1:0] r_poll_cnt;
  logic               r_to_pend;
  logic               r_timeout;

  assign w_expired = (r_poll_cnt == c_CNT_MAX);
  assign timeout_o = r_timeout;

  // Held at zero outside POLL, so every entry to POLL starts a fresh count.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_poll_cnt <= '0;
    end else if (r_state != S_POLL) begin
      r_poll_cnt <= '0;
    end else if (!w_expired) begin
      r_poll_cnt <= r_poll_cnt + c_CNT_W'(1);
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  // Requester 1 wins a tie only when requester 0 was served last.
  always_comb begin
    w_pick = 2'b00;
    case (req_i)
      2'b01:   w_pick = 2'b01;
      2'b10:   w_pick = 2'b10;
      2'b11:   w_pick = r_last ? 2'b01 : 2'b10;
      default: w_pick = 2'b00;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:        w_nxt = S_WR_PRESCALE;
      S_WR_PRESCALE: w_nxt = S_WR_SLAVE;
      S_WR_SLAVE:    w_nxt = w_rw ? S_WR_CMD_GO : S_WR_TXDATA;
      S_WR_TXDATA:   w_nxt = S_WR_CMD_GO;
      S_WR_CMD_GO:   w_nxt = S_POLL;
      S_POLL: begin
        if (w_status_ok)    w_nxt = w_rw ? S_RD_DATA : S_WR_CMD_STOP;
        else if (w_expired) w_nxt = S_WR_CMD_STOP;
        else                w_nxt = S_POLL;
      end
      S_RD_DATA:     w_nxt = S_WR_CMD_STOP;
      S_WR_CMD_STOP: w_nxt = S_DONE;
      default:       w_nxt = S_IDLE;
    endcase
  end

  // SETUP-phase address/direction/data of the transfer belonging to w_nxt.
  always_comb begin
    w_tgt_addr  = '0;
    w_tgt_write = 1'b0;
    w_tgt_wdata = '0;
    case (w_nxt)
      S_WR_PRESCALE: begin
        w_tgt_addr  = ADDR_PRESCALE;
        w_tgt_write = 1'b1;
        w_tgt_wdata = DATA_SIZE'(prescale_i);
      end
      S_WR_SLAVE: begin
        w_tgt_addr  = ADDR_SLAVE;
        w_tgt_write = 1'b1;
        w_tgt_wdata = DATA_SIZE'(r_addr);
      end
      S_WR_TXDATA: begin
        w_tgt_addr  = ADDR_TRANSMIT;
        w_tgt_write = 1'b1;
        w_tgt_wdata = DATA_SIZE'(r_wdata);
      end
      S_WR_CMD_GO: begin
        w_tgt_addr  = ADDR_COMMAND;
        w_tgt_write = 1'b1;
        w_tgt_wdata = c_CMD_GO;
      end
      S_POLL:        w_tgt_addr = ADDR_STATUS;
      S_RD_DATA:     w_tgt_addr = ADDR_RECEIVE;
      S_WR_CMD_STOP: begin
        w_tgt_addr  = ADDR_COMMAND;
        w_tgt_write = 1'b1;
        w_tgt_wdata = c_CMD_STOP;
      end
      default: begin
        w_tgt_addr  = '0;
        w_tgt_write = 1'b0;
        w_tgt_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_state   <= S_IDLE;
      r_gnt     <= 2'b00;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      r_to_pend <= 1'b0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_pick != 2'b00) begin
            r_gnt     <= w_pick;
            r_last    <= w_pick[1];
            r_busy    <= 1'b1;
            r_addr    <= w_pick[1] ? req1_addr_i  : req0_addr_i;
            r_wdata   <= w_pick[1] ? req1_wdata_i : req0_wdata_i;
            r_state   <= w_nxt;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= w_tgt_addr;
            r_pwrite  <= w_tgt_write;
            r_pwdata  <= w_tgt_wdata;
`ifdef I2C_SEQ_TIMEOUT_EN
            r_to_pend <= 1'b0;
`endif
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          if (!r_penable) begin
            r_penable <= 1'b1;
          end else if (pready_i) begin
            r_state <= w_nxt;
            if (r_state == S_RD_DATA) r_rdata <= prdata_i[7:0];
`ifdef I2C_SEQ_TIMEOUT_EN
            if (r_state == S_POLL && !w_status_ok && w_expired) r_to_pend <= 1'b1;
`endif
            if (w_nxt == S_DONE) begin
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
              r_gnt     <= 2'b00;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_paddr   <= '0;
              r_pwrite  <= 1'b0;
              r_pwdata  <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
              r_timeout <= r_to_pend;
`endif
            end else begin
              r_penable <= 1'b0;
              r_paddr   <= w_tgt_addr;
              r_pwrite  <= w_tgt_write;
              r_pwdata  <= w_tgt_wdata;
            end
          end
        end
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign done_o    = r_done;
  assign rdata_o   = r_rdata;
  assign busy_o    = r_busy;
  assign paddr_o   = r_paddr;
  assign pwrite_o  = r_pwrite;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign pwdata_o  = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_i2c_apb_sequencer.sv
// ============================================================================
// Module   : tb_i2c_apb_sequencer
// Purpose  : Randomized scoreboard bench for i2c_apb_sequencer with an APB
//            slave model of the i2c_top register map.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_apb_sequencer;

  localparam int c_JOBS = 40;

  logic       pclk_i = 1'b0;
  logic       preset_ni;
  logic [7:0] prescale_i;
  logic [1:0] req_i;
  logic [7:0] req0_addr_i, req0_wdata_i, req1_addr_i, req1_wdata_i;
  logic [1:0] gnt_o;
  logic       done_o, busy_o;
  logic [7:0] rdata_o;
  logic [7:0] paddr_o, pwdata_o, prdata_i;
  logic       pwrite_o, psel_o, penable_o, pready_i;
`ifdef I2C_SEQ_TIMEOUT_EN
  logic       timeout_o;
`endif

  i2c_apb_sequencer dut (
    .pclk_i       (pclk_i),
    .preset_ni    (preset_ni),
    .prescale_i   (prescale_i),
    .req_i        (req_i),
    .req0_addr_i  (req0_addr_i),
    .req0_wdata_i (req0_wdata_i),
    .req1_addr_i  (req1_addr_i),
    .req1_wdata_i (req1_wdata_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
`ifdef I2C_SEQ_TIMEOUT_EN
    .timeout_o    (timeout_o),
`endif
    .paddr_o      (paddr_o),
    .pwrite_o     (pwrite_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i)
  );

  always #5 pclk_i = ~pclk_i;

  // kind: 0 = grant (d = one-hot grant), 1 = APB transfer, 2 = job done (d = rdata)
  typedef struct {
    int         kind;
    logic [7:0] a;
    logic       w;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int         plan_polls = 0;
  int         plan_wmode = 0;
  logic [7:0] plan_rbyte = 8'h00;
  int         poll_idx   = 0;
  int         cur_wait   = 0;
  int         acc_cnt    = 0;

  bit         m_last  = 1'b1;
  logic [7:0] m_rdata = 8'h00;
  bit         pend[2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic take(input int kind, input string nm, output exp_t e, output bit ok);
    ok = (q.size() != 0) && (q[0].kind == kind);
    if (ok) begin
      e = q.pop_front();
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got DUT event kind %0d, required scoreboard head kind %0d (t=%0t)",
               nm, kind, (q.size() != 0) ? q[0].kind : -1, $time);
    end
  endtask

  // Expected APB traffic of one job, derived from the register-level job recipe.
  task automatic push_job(input int w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] presc, input int polls, input logic [7:0] rb);
    q.push_back('{kind: 0, a: 8'h00, w: 1'b0, d: (w == 0) ? 8'h01 : 8'h02});
    q.push_back('{kind: 1, a: 8'h00, w: 1'b1, d: presc});
    q.push_back('{kind: 1, a: 8'h05, w: 1'b1, d: a});
    if (!a[0]) q.push_back('{kind: 1, a: 8'h03, w: 1'b1, d: d});
    q.push_back('{kind: 1, a: 8'h01, w: 1'b1, d: 8'hC0});
    for (int i = 0; i <= polls; i++) q.push_back('{kind: 1, a: 8'h02, w: 1'b0, d: 8'h00});
    if (a[0]) begin
      q.push_back('{kind: 1, a: 8'h04, w: 1'b0, d: 8'h00});
      m_rdata = rb;
    end
    q.push_back('{kind: 1, a: 8'h01, w: 1'b1, d: 8'h80});
    q.push_back('{kind: 2, a: 8'h00, w: 1'b0, d: m_rdata});
  endtask

  task automatic new_req_data(input int i);
    if (i == 0) begin
      req0_addr_i  = 8'($urandom);
      req0_wdata_i = 8'($urandom);
    end else begin
      req1_addr_i  = 8'($urandom);
      req1_wdata_i = 8'($urandom);
    end
  endtask

  task automatic plan_and_push(input int w);
    plan_polls = $urandom_range(0, 3);
    plan_rbyte = 8'($urandom);
    plan_wmode = $urandom_range(0, 2);
    prescale_i = 8'($urandom);
    m_last     = (w == 1);
    push_job(w, (w == 1) ? req1_addr_i : req0_addr_i, (w == 1) ? req1_wdata_i : req0_wdata_i,
             prescale_i, plan_polls, plan_rbyte);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge pclk_i);
      ok = (gnt_o != 2'b00);
    end
    chk("grant_within_bound", ok, 1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge pclk_i);
      ok = done_o;
    end
    chk("done_within_bound", ok, 1);
  endtask

  // hold=1 keeps both requests asserted across jobs with unchanged data.
  task automatic run_job(input bit hold);
    int w;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && (hold || $urandom_range(0, 1) == 1)) begin
        pend[i] = 1'b1;
        new_req_data(i);
      end
    end
    if (!pend[0] && !pend[1]) begin
      pend[0] = 1'b1;
      new_req_data(0);
    end
    w = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
    plan_and_push(w);
    req_i = {pend[1], pend[0]};
    wait_grant(ok);
    if (!hold) begin
      pend[w] = 1'b0;
      req_i   = {pend[1], pend[0]};
      new_req_data(w);
      if (!pend[1-w] && $urandom_range(0, 2) == 0) begin
        repeat (2) @(negedge pclk_i);
        req_i[1-w] = 1'b1;
        repeat (2) @(negedge pclk_i);
        req_i[1-w] = 1'b0;
      end
    end
    wait_done();
  endtask

  task automatic reset_test();
    bit ok;
    pend[1] = 1'b0;
    pend[0] = 1'b1;
    new_req_data(0);
    req0_addr_i[0] = 1'b0;
    plan_and_push(0);
    req_i = 2'b01;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge pclk_i);
      #2;
      ok = psel_o && penable_o && (paddr_o == 8'h03);
    end
    chk("txdata_access_reached", ok, 1);
    preset_ni = 1'b0;
    #1;
    chk("async_rst_apb", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o}, 0);
    chk("async_rst_job", {gnt_o, busy_o, done_o, rdata_o}, 0);
    q.delete();
    m_last  = 1'b1;
    m_rdata = 8'h00;
    repeat (2) @(negedge pclk_i);
    pend[1] = 1'b1;
    new_req_data(1);
    preset_ni = 1'b1;
    run_job(1'b0);
  endtask

  // APB slave: random wait states, status bits per job plan, noise elsewhere.
  always begin
    @(posedge pclk_i);
    #1;
    pready_i = 1'b0;
    prdata_i = 8'($urandom);
    if (psel_o && !penable_o) begin
      cur_wait = (plan_wmode == 0) ? 0 : (plan_wmode == 1) ? 3 : $urandom_range(0, 3);
      acc_cnt  = 0;
    end else if (psel_o && penable_o) begin
      if (acc_cnt == cur_wait) begin
        pready_i = 1'b1;
        if (paddr_o == 8'h02) begin
          if (dut.r_addr[0]) prdata_i[3] = (poll_idx < plan_polls);
          else               prdata_i[7] = (poll_idx >= plan_polls);
          poll_idx++;
        end else if (paddr_o == 8'h04) begin
          prdata_i = plan_rbyte;
        end else if (paddr_o == 8'h01) begin
          poll_idx = 0;
        end
      end
      acc_cnt++;
    end
  end

  logic [1:0] prev_gnt  = 2'b00;
  logic [7:0] s_addr    = 8'h00;
  logic [7:0] s_wdata   = 8'h00;
  logic       s_write   = 1'b0;
  int         s_cycles  = 0;
  bit         s_stable  = 1'b1;
  bit         want_setup = 1'b0;

  always @(negedge pclk_i) begin : mon
    exp_t e;
    bit   ok;
    if (preset_ni) begin
      chk("gnt_not_two_hot", ($countones(gnt_o) <= 1) ? 1 : 0, 1);
      if (want_setup) begin
        chk("no_idle_between_xfers", {psel_o, penable_o}, 2'b10);
        want_setup = 1'b0;
      end
      if (gnt_o != prev_gnt && gnt_o != 2'b00) begin
        take(0, "grant_event", e, ok);
        if (ok) chk("grant", {busy_o, gnt_o}, {1'b1, e.d[1:0]});
      end
      if (psel_o && !penable_o) begin
        s_addr   = paddr_o;
        s_wdata  = pwdata_o;
        s_write  = pwrite_o;
        s_cycles = 1;
        s_stable = 1'b1;
      end else if (psel_o && penable_o) begin
        s_cycles++;
        if (paddr_o !== s_addr || pwdata_o !== s_wdata || pwrite_o !== s_write) s_stable = 1'b0;
        if (pready_i) begin
          take(1, "xfer_event", e, ok);
          if (ok) begin
            chk("xfer_addr", paddr_o, e.a);
            chk("xfer_dir", pwrite_o, e.w);
            if (e.w) chk("xfer_wdata", pwdata_o, e.d);
            chk("xfer_stable", s_stable, 1);
            chk("xfer_len", s_cycles, cur_wait + 2);
            want_setup = (q.size() != 0) && (q[0].kind == 1);
          end
        end
      end
      if (done_o) begin
        take(2, "done_event", e, ok);
        if (ok) begin
          chk("done_rdata", rdata_o, e.d);
          chk("done_clears_gnt_busy_psel", {gnt_o, busy_o, psel_o}, 0);
`ifdef I2C_SEQ_TIMEOUT_EN
          chk("done_no_timeout", timeout_o, 0);
`endif
        end
      end
    end
    prev_gnt = gnt_o;
  end

  initial begin
    preset_ni    = 1'b0;
    prescale_i   = 8'h00;
    req_i        = 2'b00;
    req0_addr_i  = 8'h00;
    req0_wdata_i = 8'h00;
    req1_addr_i  = 8'h00;
    req1_wdata_i = 8'h00;
    pready_i     = 1'b0;
    prdata_i     = 8'h00;
    repeat (3) @(negedge pclk_i);
    chk("reset_outputs",
        {gnt_o, done_o, busy_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rdata_o}, 0);
    preset_ni = 1'b1;
    @(negedge pclk_i);
    for (int j = 0; j < c_JOBS; j++) run_job(j < 6);
    reset_test();
    for (int j = 0; j < 4; j++) run_job(1'b0);
    req_i   = 2'b00;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (10) @(negedge pclk_i);
    chk("scoreboard_drained", q.size(), 0);
    chk("idle_at_end", {busy_o, gnt_o, psel_o}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
